// File: rtl/uart_pkg.sv
// Shared register map, STATUS/CTRL bit positions and serializer state encoding
// for the memory-mapped UART transmitter.
package uart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_DIV    = 2'd3;

    localparam int ST_BUSY  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_COUNT = 4;

    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_PAR_EN = 2;
    localparam int CTRL_ODD    = 3;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Power-of-two TX FIFO with combinational head read; a push into a full FIFO
// is accepted only when a pop happens in the same cycle. Reset flushes it.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter: DATA/STATUS/CTRL/DIV registers, TX FIFO, divisor-timed serializer, TX-done irq.
// Optional UART_PARITY_EN adds CTRL[2]=par_en, CTRL[3]=odd and a parity bit ahead of STOP.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cs,
    input  logic        i_wr,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_tx,
    output logic        o_irq
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W = $clog2(DATA_BITS);
`ifdef UART_PARITY_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h3;
`endif

    tx_state_e            r_state;
    logic [3:0]           r_ctrl;
    logic [DIV_W-1:0]     r_div;
    logic [DIV_W-1:0]     r_bit_div;
    logic [DIV_W-1:0]     r_cnt;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 r_ovf;
    logic                 r_par_en;
    logic                 r_par_bit;
    logic [31:0]          r_rdata;

    logic                 w_push_req;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_bit_end;
    logic                 w_busy;
    logic [CNT_W-1:0]     w_count;
    logic [DATA_BITS-1:0] w_head;
    logic [31:0]          w_status;
    logic [31:0]          w_rd_mux;
    logic                 w_unused;

    assign w_unused   = ^i_wdata;
    assign w_push_req = i_cs & i_wr & (i_addr == ADDR_DATA);
    assign w_bit_end  = (r_cnt == r_bit_div - DIV_W'(1));
    assign w_busy     = (r_state != TX_IDLE);
    // The last STOP cycle doubles as the IDLE pop cycle so queued frames run without a gap.
    assign w_pop      = ((r_state == TX_IDLE) | ((r_state == TX_STOP) & w_bit_end))
                        & r_ctrl[CTRL_TX_EN] & ~w_empty;

    assign o_tx    = r_tx;
    assign o_rdata = r_rdata;
    assign o_irq   = r_ctrl[CTRL_IRQ_EN] & w_empty & ~w_busy;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push_req),
        .i_wdata (i_wdata[DATA_BITS-1:0]),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_status                     = '0;
        w_status[ST_BUSY]            = w_busy;
        w_status[ST_EMPTY]           = w_empty;
        w_status[ST_FULL]            = w_full;
        w_status[ST_OVF]             = r_ovf;
        w_status[ST_COUNT +: CNT_W]  = w_count;
    end

    always_comb begin
        w_rd_mux = '0;
        case (i_addr)
            ADDR_STATUS: w_rd_mux = w_status;
            ADDR_CTRL:   w_rd_mux = 32'(r_ctrl);
            ADDR_DIV:    w_rd_mux = 32'(r_div);
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ctrl  <= '0;
            r_div   <= DIV_W'(DEFAULT_DIV);
            r_ovf   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_push_req & w_full & ~w_pop) r_ovf <= 1'b1;
            if (i_cs & i_wr) begin
                case (i_addr)
                    ADDR_STATUS: if (i_wdata[ST_OVF]) r_ovf <= 1'b0;
                    ADDR_CTRL:   r_ctrl <= i_wdata[3:0] & CTRL_MASK;
                    ADDR_DIV:    r_div  <= (i_wdata[DIV_W-1:0] == '0) ? DIV_W'(1) : i_wdata[DIV_W-1:0];
                    default:     ;
                endcase
            end
            if (i_cs & ~i_wr) r_rdata <= w_rd_mux;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= TX_IDLE;
            r_tx      <= 1'b1;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_bit_div <= DIV_W'(DEFAULT_DIV);
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else begin
            r_cnt <= w_bit_end ? '0 : r_cnt + DIV_W'(1);
            case (r_state)
                TX_IDLE: begin
                    r_tx  <= 1'b1;
                    r_cnt <= '0;
                end
                TX_START: if (w_bit_end) begin
                    r_state <= TX_DATA;
                    r_tx    <= r_shift[0];
                    r_shift <= r_shift >> 1;
                    r_bit   <= '0;
                end
                TX_DATA: if (w_bit_end) begin
                    if (r_bit == BIT_W'(DATA_BITS - 1)) begin
                        if (r_par_en) begin
                            r_state <= TX_PARITY;
                            r_tx    <= r_par_bit;
                        end else begin
                            r_state <= TX_STOP;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_bit   <= r_bit + BIT_W'(1);
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                TX_PARITY: if (w_bit_end) begin
                    r_state <= TX_STOP;
                    r_tx    <= 1'b1;
                end
                TX_STOP: if (w_bit_end) r_state <= TX_IDLE;
                default: r_state <= TX_IDLE;
            endcase
            // Divisor and parity mode are captured per frame so mid-frame CTRL/DIV writes wait.
            if (w_pop) begin
                r_state   <= TX_START;
                r_tx      <= 1'b0;
                r_cnt     <= '0;
                r_shift   <= w_head;
                r_bit_div <= r_div;
                r_par_en  <= r_ctrl[CTRL_PAR_EN];
                r_par_bit <= (^w_head) ^ r_ctrl[CTRL_ODD];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed + randomized bench: the expected serial line is built frame by frame from the byte stream.
`timescale 1ns/1ps
module tb_uart_tx_mmio;
    localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_DIV = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int total = 0;
    int bad = 0;
    logic txlog[$];
    logic irqlog[$];
    logic expq[$];

    uart_tx_mmio dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_cs    (cs),
        .i_wr    (wr),
        .i_addr  (addr),
        .i_wdata (wdata),
        .o_rdata (rdata),
        .o_tx    (tx),
        .o_irq   (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        txlog.push_back(tx);
        irqlog.push_back(irq);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        cs = 1'b1; wr = 1'b0; addr = a;
        @(posedge clk); #1;
        cs = 1'b0;
        d = rdata;
    endtask

    function automatic logic [31:0] st(input bit busy, input bit empty, input bit full,
                                        input bit ovf, input int cnt);
        return (32'(cnt) << 4) | {28'd0, ovf, full, empty, busy};
    endfunction

    function automatic void add_bits(input logic v, input int n);
        for (int k = 0; k < n; k++) expq.push_back(v);
    endfunction

    // par: -1 none, 0 even, 1 odd
    function automatic void add_frame(input logic [7:0] b, input int div, input int par);
        add_bits(1'b0, div);
        for (int k = 0; k < 8; k++) add_bits(b[k], div);
        if (par >= 0) add_bits((^b) ^ par[0], div);
        add_bits(1'b1, div);
    endfunction

    task automatic check_log(input string tag, input int s, input bit use_irq);
        int guard = 0;
        int nbad = 0;
        int first = -1;
        logic o, fo, fe;
        fo = 1'bx; fe = 1'bx;
        while (txlog.size() < s + expq.size() && guard < 20000) begin
            @(posedge clk); #1;
            guard++;
        end
        foreach (expq[i]) begin
            if (s + i < txlog.size()) o = use_irq ? irqlog[s + i] : txlog[s + i];
            else o = 1'bx;
            if (o !== expq[i]) begin
                nbad++;
                if (first < 0) begin first = i; fo = o; fe = expq[i]; end
            end
        end
        total++;
        assert (nbad == 0) else begin
            bad++;
            $error("FAIL %s: %0d sample mismatches, first at %0d got %b expected %b", tag, nbad, first, fo, fe);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b, b2;
        logic [7:0]  bytes[$];
        int s, div, n;

        repeat (3) @(posedge clk); #1;
        chk("reset_tx", tx, 1);
        chk("reset_rdata", rdata, 0);
        chk("reset_irq", irq, 0);
        reset = 1'b0;
        bus_rd(A_STATUS, d); chk("reset_status", d, st(0, 1, 0, 0, 0));
        bus_rd(A_CTRL, d);   chk("reset_ctrl", d, 0);
        bus_rd(A_DIV, d);    chk("reset_div", d, 868);
        bus_rd(A_DATA, d);   chk("data_reads_zero", d, 0);
        bus_wr(A_DIV, 0);
        bus_rd(A_DIV, d);    chk("div_zero_stores_one", d, 1);
`ifdef UART_PARITY_EN
        bus_wr(A_CTRL, 32'hF);
        bus_rd(A_CTRL, d);   chk("ctrl_rw", d, 32'hF);
`else
        bus_wr(A_CTRL, 32'hF);
        bus_rd(A_CTRL, d);   chk("ctrl_par_bits_ignored", d, 32'h3);
`endif
        bus_wr(A_CTRL, 0);

        // Single 0xA5 frame at DIV=4, busy exactly 40 clocks
        bus_wr(A_DIV, 4);
        bus_wr(A_CTRL, 1);
        bus_wr(A_DATA, 32'hA5);
        s = txlog.size();
        bus_rd(A_STATUS, d); chk("t1_status_before_pop", d, st(0, 0, 0, 0, 1));
        bus_rd(A_STATUS, d); chk("t1_status_busy", d, st(1, 1, 0, 0, 0));
        repeat (38) @(posedge clk); #1;
        bus_rd(A_STATUS, d); chk("t1_busy_last_clk", d[0], 1);
        bus_rd(A_STATUS, d); chk("t1_busy_cleared", d[0], 0);
        expq.delete(); add_bits(1, 1); add_frame(8'hA5, 4, -1); add_bits(1, 3);
        check_log("t1_wave", s, 0);

        // Random bytes at a random divisor, queued back to back
        div = $urandom_range(1, 3);
        n = $urandom_range(2, 4);
        bus_wr(A_DIV, div);
        expq.delete(); add_bits(1, 1);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            bus_wr(A_DATA, 32'(b));
            if (i == 0) s = txlog.size();
            add_frame(b, div, -1);
        end
        add_bits(1, 3);
        check_log("rand_wave", s, 0);

        // Overflow: 17 pushes into 16 entries, W1C, then drain the retained 16
        bus_wr(A_CTRL, 0);
        bus_wr(A_DIV, 1);
        bytes.delete();
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom_range(0, 255));
            bus_wr(A_DATA, 32'(b));
            if (i < 16) bytes.push_back(b);
        end
        bus_rd(A_STATUS, d); chk("t2_full_ovf", d, st(0, 0, 1, 1, 16));
        bus_wr(A_STATUS, 32'h7);
        bus_rd(A_STATUS, d); chk("t2_ovf_sticky", d, st(0, 0, 1, 1, 16));
        bus_wr(A_STATUS, 32'h8);
        bus_rd(A_STATUS, d); chk("t2_ovf_w1c", d, st(0, 0, 1, 0, 16));
        bus_wr(A_CTRL, 1);
        s = txlog.size();
        expq.delete(); add_bits(1, 1);
        foreach (bytes[i]) add_frame(bytes[i], 1, -1);
        add_bits(1, 3);
        check_log("t2_drain_wave", s, 0);
        bus_rd(A_STATUS, d); chk("t2_drained", d, st(0, 1, 0, 0, 0));

        // Two back-to-back frames, irq once the second stop bit is done
        bus_wr(A_DIV, 2);
        bus_wr(A_CTRL, 3);
        chk("t3_irq_idle", irq, 1);
        bus_wr(A_DATA, 32'h55);
        s = txlog.size();
        bus_wr(A_DATA, 32'h0F);
        expq.delete(); add_bits(1, 1); add_frame(8'h55, 2, -1); add_frame(8'h0F, 2, -1); add_bits(1, 3);
        check_log("t3_wave", s, 0);
        expq.delete(); add_bits(0, 1 + 40); add_bits(1, 3);
        check_log("t3_irq", s, 1);

        // Divisor rewritten mid-frame only affects the following frame
        bus_wr(A_CTRL, 1);
        b  = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        bus_wr(A_DATA, 32'(b));
        s = txlog.size();
        bus_wr(A_DATA, 32'(b2));
        bus_wr(A_DIV, 8);
        expq.delete(); add_bits(1, 1); add_frame(b, 2, -1); add_frame(b2, 8, -1); add_bits(1, 3);
        check_log("t4_wave", s, 0);

`ifdef UART_PARITY_EN
        bus_wr(A_DIV, 1);
        bus_wr(A_CTRL, 5);
        bus_wr(A_DATA, 32'h07);
        s = txlog.size();
        expq.delete(); add_bits(1, 1); add_frame(8'h07, 1, 0); add_bits(1, 3);
        check_log("t6_even_wave", s, 0);
        bus_wr(A_CTRL, 32'hD);
        bus_wr(A_DATA, 32'h07);
        s = txlog.size();
        expq.delete(); add_bits(1, 1); add_frame(8'h07, 1, 1); add_bits(1, 3);
        check_log("t6_odd_wave", s, 0);
`endif

        // Reset in the middle of a zero byte's data bits
        bus_wr(A_DIV, 4);
        bus_wr(A_CTRL, 1);
        for (int i = 0; i < 3; i++) bus_wr(A_DATA, 0);
        repeat (8) @(posedge clk); #1;
        chk("t5_tx_low_pre_reset", tx, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_tx_after_reset", tx, 1);
        reset = 1'b0;
        bus_rd(A_STATUS, d); chk("t5_status_flushed", d, st(0, 1, 0, 0, 0));
        bus_rd(A_CTRL, d);   chk("t5_ctrl_cleared", d, 0);
        bus_rd(A_DIV, d);    chk("t5_div_default", d, 868);
        repeat (5) @(posedge clk); #1;
        chk("t5_tx_stays_idle", tx, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
